serial_alu_ctrl: RTL and testbench

// - Bit-serial ALU sequencer: accepts a WIDTH-bit operation, drives a one-bit ALU cell LSB-first
//   for WIDTH cycles, chains carry through a register, assembles result and flags.
// - Area-reduced alternative to the ripple ALU; sits between the decode stage and the register-file writeback.

---
 rtl/serial_alu_ctrl_pkg.sv | 27 ++
 rtl/serial_alu_ctrl_bit_cell.sv | 47 ++++
 rtl/serial_alu_ctrl.sv | 162 ++++++++++++++++
 tb/tb_serial_alu_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_ctrl_pkg.sv
// Shared opcode and state encodings for the bit-serial ALU sequencer.
package serial_alu_ctrl_pkg;

  localparam logic [2:0] ADD_  = 3'd0;
  localparam logic [2:0] SUB_  = 3'd1;
  localparam logic [2:0] XOR_  = 3'd2;
  localparam logic [2:0] SLT_  = 3'd3;
  localparam logic [2:0] AND_  = 3'd4;
  localparam logic [2:0] NAND_ = 3'd5;
  localparam logic [2:0] NOR_  = 3'd6;
  localparam logic [2:0] OR_   = 3'd7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Opcodes whose result comes from the adder and report carry/overflow.
  function automatic logic is_arith(input logic [2:0] ctrl);
    return (ctrl == ADD_) || (ctrl == SUB_) || (ctrl == SLT_);
  endfunction

  // Subtracting opcodes add ~b + 1, so the chain starts with carry set.
  function automatic logic carry_init(input logic [2:0] ctrl);
    return (ctrl == SUB_) || (ctrl == SLT_);
  endfunction

endpackage

// File: rtl/serial_alu_ctrl_bit_cell.sv
// serial_bit_cell: combinational one-bit ALU slice (A, B, Cin, Ctrl -> R, Cout).
// DLY is a simulation-only delay hint; the synthesizable cell has zero delay.
module serial_bit_cell
  import serial_alu_ctrl_pkg::*;
#(
  parameter int DLY = 5
) (
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_cin,
  input  logic [2:0] i_ctrl,
  output logic       o_r,
  output logic       o_cout
);

  if (DLY < 0) begin : g_bad_dly
    $error("serial_bit_cell: DLY must be non-negative");
  end

  logic w_b_eff;
  logic w_sum;

  // Adder operand: B inverted only for the subtracting opcodes.
  always_comb begin
    if (carry_init(i_ctrl)) begin
      w_b_eff = ~i_b;
    end else begin
      w_b_eff = i_b;
    end
    w_sum  = i_a ^ w_b_eff ^ i_cin;
    o_cout = (i_a & w_b_eff) | (i_a & i_cin) | (w_b_eff & i_cin);
  end

  // Result bit select.
  always_comb begin
    case (i_ctrl)
      ADD_, SUB_, SLT_: o_r = w_sum;
      XOR_:             o_r = i_a ^ i_b;
      AND_:             o_r = i_a & i_b;
      NAND_:            o_r = ~(i_a & i_b);
      NOR_:             o_r = ~(i_a | i_b);
      OR_:              o_r = i_a | i_b;
      default:          o_r = i_a & i_b;
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: one serial_bit_cell walked LSB-first over WIDTH cycles.
// Optional abort input enabled by defining SERIAL_ALU_ABORT_EN.
module serial_alu_ctrl
  import serial_alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DLY   = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [2:0]       i_ctrl,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
`ifdef SERIAL_ALU_ABORT_EN
  input  logic             i_abort,
`endif
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carryout,
  output logic             o_overflow,
  output logic             o_zero
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("serial_alu_ctrl: WIDTH must be in 2..64");
  end

  logic [1:0]       r_state;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_ctrl;
  logic [WIDTH-2:0] r_res;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_carryout;
  logic             r_overflow;
  logic             r_zero;

  logic             w_r;
  logic             w_cout;
  logic             w_abort;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] w_final;
  logic             w_ovf;
  logic             w_cflag;

`ifdef SERIAL_ALU_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  serial_bit_cell #(.DLY(DLY)) u_cell (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_cin  (r_carry),
    .i_ctrl (r_ctrl),
    .o_r    (w_r),
    .o_cout (w_cout)
  );

  // Final result and flags, meaningful on the cycle the MSB is processed.
  always_comb begin
    w_res_next = {w_r, r_res};
    if (is_arith(r_ctrl)) begin
      w_ovf   = r_carry ^ w_cout;
      w_cflag = w_cout;
    end else begin
      w_ovf   = 1'b0;
      w_cflag = 1'b0;
    end
    if (r_ctrl == SLT_) begin
      w_final = {{(WIDTH-1){1'b0}}, w_r ^ w_ovf};
    end else begin
      w_final = w_res_next;
    end
  end

  // Sequencer FSM, operand/result shift registers and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_idx      <= {IW{1'b0}};
      r_carry    <= 1'b0;
      r_a        <= {WIDTH{1'b0}};
      r_b        <= {WIDTH{1'b0}};
      r_ctrl     <= 3'd0;
      r_res      <= {(WIDTH-1){1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= {WIDTH{1'b0}};
      r_carryout <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= S_RUN;
            r_a     <= i_a;
            r_b     <= i_b;
            r_ctrl  <= i_ctrl;
            r_carry <= carry_init(i_ctrl);
            r_idx   <= {IW{1'b0}};
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_res   <= w_res_next[WIDTH-1:1];
            r_carry <= w_cout;
            r_idx   <= r_idx + 1'b1;
            if (r_idx == LAST_IDX) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_result   <= w_final;
              r_carryout <= w_cflag;
              r_overflow <= w_ovf;
              r_zero     <= (w_final == {WIDTH{1'b0}});
            end else begin
              r_state    <= S_RUN;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_result   = r_result;
  assign o_carryout = r_carryout;
  assign o_overflow = r_overflow;
  assign o_zero     = r_zero;

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed self-checking bench for serial_alu_ctrl at WIDTH=32.
module tb_serial_alu_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic [2:0]    i_ctrl;
  logic [W-1:0]  i_a;
  logic [W-1:0]  i_b;
`ifdef SERIAL_ALU_ABORT_EN
  logic          i_abort;
`endif
  logic          o_busy;
  logic          o_done;
  logic [W-1:0]  o_result;
  logic          o_carryout;
  logic          o_overflow;
  logic          o_zero;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_alu_ctrl #(.WIDTH(W), .DLY(5)) dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_ctrl     (i_ctrl),
    .i_a        (i_a),
    .i_b        (i_b),
`ifdef SERIAL_ALU_ABORT_EN
    .i_abort    (i_abort),
`endif
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_result   (o_result),
    .o_carryout (o_carryout),
    .o_overflow (o_overflow),
    .o_zero     (o_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op; inputs are scrambled right after accept. Returns edges until done.
  task automatic run_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    @(negedge clk);
    i_ctrl = c; i_a = a; i_b = b; i_start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    i_start = 1'b0; i_a = ~a; i_b = ~b; i_ctrl = c ^ 3'd6;
    while (!o_done && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic check_op(input string tag, input logic [2:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] res,
                          input logic co, input logic ov, input logic z);
    int lat;
    run_op(c, a, b, lat);
    chk({tag, "_lat"}, 64'(lat), 64'd33);
    chk({tag, "_res"}, 64'(o_result), 64'(res));
    chk({tag, "_flags"}, {61'd0, o_carryout, o_overflow, o_zero}, {61'd0, co, ov, z});
  endtask

  initial begin
    int lat;
    int ndone;
    int first_at;
    int second_at;
    logic [W-1:0] held;
    i_reset = 1'b1; i_start = 1'b0; i_ctrl = 3'd0; i_a = '0; i_b = '0;
`ifdef SERIAL_ALU_ABORT_EN
    i_abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    chk("reset_state", {58'd0, o_busy, o_done, o_carryout, o_overflow, o_zero, 1'b0},
        64'd0);
    chk("reset_result", 64'(o_result), 64'd0);

    // ADD with full-width carry; also busy/done relationship across DONE.
    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, lat);
    chk("add_lat", 64'(lat), 64'd33);
    chk("add_busy_in_done", 64'(o_busy), 64'd1);
    chk("add_res", 64'(o_result), 64'd0);
    chk("add_flags", {61'd0, o_carryout, o_overflow, o_zero}, 64'b101);
    @(negedge clk);
    chk("add_after", {62'd0, o_busy, o_done}, 64'd0);
    chk("add_hold", {31'd0, o_zero, o_result}, {31'd0, 1'b1, 32'd0});

    check_op("sub", 3'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    check_op("slt_lt", 3'd3, 32'hFFFF_FFFB, 32'h0000_0003, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    check_op("slt_ge", 3'd3, 32'h0000_0003, 32'hFFFF_FFFB, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    check_op("and",  3'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0, 1'b0);
    check_op("nand", 3'd5, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF0F_EDCB, 1'b0, 1'b0, 1'b0);
    check_op("nor",  3'd6, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h000F_0000, 1'b0, 1'b0, 1'b0);
    check_op("or",   3'd7, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFFF0_FFFF, 1'b0, 1'b0, 1'b0);
    check_op("xor",  3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b0, 1'b0, 1'b0);

    // Reset at cycle 10 of an ADD.
    @(negedge clk);
    i_ctrl = 3'd0; i_a = 32'd100; i_b = 32'd200; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (9) @(negedge clk);
    chk("rst_mid_busy_before", 64'(o_busy), 64'd1);
    i_reset = 1'b1;
    #1;
    chk("rst_mid_outputs", {o_busy, o_done, o_carryout, o_overflow, o_zero, o_result},
        64'd0);
    @(negedge clk);
    i_reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_done) ndone++;
    end
    chk("rst_mid_no_done", 64'(ndone), 64'd0);
    check_op("after_rst", 3'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0);

    // start held high: one op per W+2 cycles.
    @(negedge clk);
    i_ctrl = 3'd0; i_a = 32'd1; i_b = 32'd1; i_start = 1'b1;
    ndone = 0; first_at = 0; second_at = 0;
    for (int k = 1; k <= 110; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (o_done) begin
        ndone++;
        if (ndone == 1) first_at = k;
        if (ndone == 2) second_at = k;
      end
    end
    i_start = 1'b0;
    chk("held_count", 64'(ndone), 64'd3);
    chk("held_first", 64'(first_at), 64'd33);
    chk("held_period", 64'(second_at - first_at), 64'd34);
    chk("held_res", 64'(o_result), 64'd2);
    repeat (40) @(negedge clk);

`ifdef SERIAL_ALU_ABORT_EN
    held = o_result;
    i_ctrl = 3'd7; i_a = 32'h1234_0000; i_b = 32'h0000_5678; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("abort_busy", 64'(o_busy), 64'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_done) ndone++;
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    chk("abort_res_kept", 64'(o_result), 64'(held));
`else
    held = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
